// File: rtl/z_core_mem_ctrl.sv
// z_core_mem_ctrl: sequences one core fetch/load/store at a time onto an AXI4-Lite master,
// with store lane strobes, load lane extraction/extension and misalign/bus error reporting.
module z_core_mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_instr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [2:0]              r_funct3;
    logic                    r_instr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_WIDTH-1:0]   r_wstrb;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic [31:0]             r_rdata;
    logic                    r_err;
    logic [2:0]              w_f3;
    logic                    w_bad_f3;
    logic                    w_misal;
    logic                    w_err_req;
    logic                    w_accept;
    logic [DATA_WIDTH-1:0]   w_st_data;
    logic [STRB_WIDTH-1:0]   w_st_strb;
    logic [DATA_WIDTH-1:0]   w_lane;
    logic [31:0]             w_ld;

    // Fetches are always word loads regardless of the funct3 the core presents
    assign w_f3      = req_instr ? 3'b010 : req_funct3;
    assign w_bad_f3  = req_we ? (w_f3[2] || w_f3[1:0] == 2'b11)
                              : (w_f3[1:0] == 2'b11 || w_f3 == 3'b110);
    assign w_misal   = (w_f3[1:0] == 2'b01 && req_addr[0]) ||
                       (w_f3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    assign w_err_req = w_bad_f3 || w_misal;
    assign w_accept  = (r_state == IDLE) && req_valid;

    assign w_st_data = (w_f3[1:0] == 2'b00) ? {4{req_wdata[7:0]}} :
                       (w_f3[1:0] == 2'b01) ? {2{req_wdata[15:0]}} : req_wdata;
    assign w_st_strb = (w_f3[1:0] == 2'b00) ? 4'b0001 << req_addr[1:0] :
                       (w_f3[1:0] == 2'b01) ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    assign w_lane = m_axil_rdata >> {r_addr[1:0], 3'b000};
    assign w_ld   = (r_funct3[1:0] == 2'b00) ? {{24{~r_funct3[2] & w_lane[7]}}, w_lane[7:0]} :
                    (r_funct3[1:0] == 2'b01) ? {{16{~r_funct3[2] & w_lane[15]}}, w_lane[15:0]} :
                    w_lane;

    assign req_ready      = (r_state == IDLE);
    assign rsp_valid      = (r_state == RESP);
    assign rsp_rdata      = r_rdata;
    assign rsp_err        = r_err;
    assign m_axil_araddr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign m_axil_awaddr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign m_axil_arprot  = r_instr ? 3'b100 : 3'b000;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_arvalid = (r_state == RD_ADDR);
    assign m_axil_rready  = (r_state == RD_DATA);
    assign m_axil_awvalid = (r_state == WR) && !r_aw_done;
    assign m_axil_wvalid  = (r_state == WR) && !r_w_done;
    assign m_axil_wdata   = r_wdata;
    assign m_axil_wstrb   = r_wstrb;
    assign m_axil_bready  = (r_state == WR_RESP);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (req_valid) w_next = w_err_req ? RESP : (req_we ? WR : RD_ADDR);
            RD_ADDR: if (m_axil_arready) w_next = RD_DATA;
            RD_DATA: if (m_axil_rvalid) w_next = RESP;
            WR:      if ((r_aw_done || m_axil_awready) && (r_w_done || m_axil_wready)) w_next = WR_RESP;
            WR_RESP: if (m_axil_bvalid) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr    <= '0;
            r_funct3  <= '0;
            r_instr   <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= req_addr;
                r_funct3  <= w_f3;
                r_instr   <= req_instr;
                r_wdata   <= w_st_data;
                r_wstrb   <= w_st_strb;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_rdata   <= '0;
                r_err     <= w_err_req;
            end
            // AW and W complete independently; each valid drops after its own handshake
            if (m_axil_awvalid && m_axil_awready) r_aw_done <= 1'b1;
            if (m_axil_wvalid && m_axil_wready) r_w_done <= 1'b1;
            if (m_axil_rready && m_axil_rvalid) begin
                r_rdata <= w_ld;
                r_err   <= (m_axil_rresp != 2'b00);
            end
            if (m_axil_bready && m_axil_bvalid) r_err <= (m_axil_bresp != 2'b00);
        end
    end
endmodule

// File: tb/tb_z_core_mem_ctrl.sv
// tb_z_core_mem_ctrl: directed bench with an AXI4-Lite slave model and a spec-level
// response model checked every cycle against rsp_valid/rsp_rdata/rsp_err.
module tb_z_core_mem_ctrl;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_instr = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] awaddr, araddr, wdata, rdata = '0;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
    logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
    logic [1:0]  bresp = '0, rresp = '0;

    always #5 clk = ~clk;

    z_core_mem_ctrl dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_instr(req_instr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f);
        return (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : (f[1:0] == 2'd2) ? 4 : 0;
    endfunction

    function automatic bit legal(input logic we, input logic instr, input logic [31:0] addr, input logic [2:0] f3);
        logic [2:0] f;
        int sz;
        f = instr ? 3'b010 : f3;
        sz = size_of(f);
        if (sz == 0 || addr % sz != 0) return 0;
        return we ? !f[2] : !(f[2] && sz == 4);
    endfunction

    // {err, rdata} the core must see for one request against a slave returning rd/rr/br
    function automatic logic [32:0] model(input logic we, input logic instr, input logic [31:0] addr,
                                          input logic [2:0] f3, input logic [31:0] rd,
                                          input logic [1:0] rr, input logic [1:0] br);
        logic [2:0]  f;
        logic [31:0] lane, v;
        int sz;
        f = instr ? 3'b010 : f3;
        sz = size_of(f);
        if (!legal(we, instr, addr, f3)) return {1'b1, 32'h0};
        if (we) return {br != 2'b00, 32'h0};
        lane = rd >> (8 * (addr % 4));
        if (sz == 1)      v = f[2] ? (lane & 32'hFF) : ((lane & 32'h80) != 0 ? (lane | 32'hFFFFFF00) : (lane & 32'hFF));
        else if (sz == 2) v = f[2] ? (lane & 32'hFFFF) : ((lane & 32'h8000) != 0 ? (lane | 32'hFFFF0000) : (lane & 32'hFFFF));
        else              v = lane;
        return {rr != 2'b00, v};
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz;
        sz = size_of(f3);
        return (sz == 1) ? (wd & 32'hFF) * 32'h01010101 : (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = size_of(f3);
        return (sz == 1) ? 4'(1 << (addr % 4)) : (sz == 2) ? 4'(3 << (addr % 4)) : 4'hF;
    endfunction

    // AXI4-Lite slave: readies after a programmable wait, responses one cycle after the address/data
    int          aw_delay = 0, w_delay = 0, aw_cnt = 0, w_cnt = 0;
    int          ar_beats = 0, aw_beats = 0, w_beats = 0, arvalid_cyc = 0, awvalid_cyc = 0;
    bit          r_hold = 0, pend_r = 0, pend_b = 0, aw_seen = 0, w_seen = 0;
    logic [31:0] s_rdata = '0, log_araddr = '0, log_awaddr = '0, log_wdata = '0;
    logic [1:0]  s_rresp = '0, s_bresp = '0;
    logic [2:0]  log_arprot = '0, log_awprot = '0;
    logic [3:0]  log_wstrb = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
            pend_r = 0; pend_b = 0; aw_seen = 0; w_seen = 0; aw_cnt = 0; w_cnt = 0;
        end else begin
            arready = 1;
            awready = awvalid && aw_cnt >= aw_delay;
            wready  = wvalid && w_cnt >= w_delay;
            rvalid  = pend_r && !r_hold;
            rdata   = s_rdata;
            rresp   = s_rresp;
            bvalid  = pend_b;
            bresp   = s_bresp;
            if (arvalid) arvalid_cyc++;
            if (awvalid) awvalid_cyc++;
            if (arvalid && arready) begin
                ar_beats++; log_araddr = araddr; log_arprot = arprot; pend_r = 1;
            end
            if (rvalid && rready) pend_r = 0;
            if (awvalid && awready) begin
                aw_beats++; log_awaddr = awaddr; log_awprot = awprot; aw_seen = 1; aw_cnt = 0;
            end else if (awvalid) aw_cnt++;
            if (wvalid && wready) begin
                w_beats++; log_wdata = wdata; log_wstrb = wstrb; w_seen = 1; w_cnt = 0;
            end else if (wvalid) w_cnt++;
            if (bvalid && bready) pend_b = 0;
            if (aw_seen && w_seen) begin
                pend_b = 1; aw_seen = 0; w_seen = 0;
            end
        end
    end

    bit          exp_active = 0, done = 0;
    int          exp_cyc = 0;
    logic [31:0] exp_rdata = '0;
    logic        exp_err = 0;

    always @(negedge clk) begin
        if (rstn) begin
            if (rsp_valid) begin
                if (!exp_active) chk("unexpected_rsp_valid", 32'd1, 32'd0);
                else begin
                    chk("rsp_cycle", cyc, exp_cyc);
                    chk("rsp_rdata", rsp_rdata, exp_rdata);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
                    exp_active = 0;
                    done = 1;
                end
            end else if (exp_active && cyc > exp_cyc) begin
                chk("rsp_missing", 32'd0, 32'd1);
                exp_active = 0;
                done = 1;
            end
        end
    end

    task automatic do_req(input string nm, input logic we, input logic instr, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd, input logic [31:0] rd,
                          input logic [1:0] rr, input logic [1:0] br);
        logic [32:0] m;
        logic [2:0]  f;
        int lat, ar0, aw0, w0, arc0, awc0;
        f = instr ? 3'b010 : f3;
        m = model(we, instr, addr, f3, rd, rr, br);
        lat = !legal(we, instr, addr, f3) ? 1 : we ? 3 + (aw_delay > w_delay ? aw_delay : w_delay) : 3;
        s_rdata = rd; s_rresp = rr; s_bresp = br;
        @(negedge clk);
        req_valid = 1; req_we = we; req_instr = instr; req_addr = addr; req_funct3 = f3; req_wdata = wd;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        ar0 = ar_beats; aw0 = aw_beats; w0 = w_beats; arc0 = arvalid_cyc; awc0 = awvalid_cyc;
        exp_cyc = cyc + lat; exp_rdata = m[31:0]; exp_err = m[32]; done = 0; exp_active = 1;
        @(negedge clk);
        req_valid = 0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A; req_funct3 = 3'b111;
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        if (!legal(we, instr, addr, f3)) begin
            chk({nm, "_no_arvalid"}, arvalid_cyc - arc0, 0);
            chk({nm, "_no_awvalid"}, awvalid_cyc - awc0, 0);
        end else if (we) begin
            chk({nm, "_awaddr"}, log_awaddr, addr & 32'hFFFF_FFFC);
            chk({nm, "_awprot"}, {29'd0, log_awprot}, 0);
            chk({nm, "_wdata"}, log_wdata, exp_wdata(f, wd));
            chk({nm, "_wstrb"}, {28'd0, log_wstrb}, {28'd0, exp_strb(f, addr)});
            chk({nm, "_aw_beats"}, aw_beats - aw0, 1);
            chk({nm, "_w_beats"}, w_beats - w0, 1);
        end else begin
            chk({nm, "_araddr"}, log_araddr, addr & 32'hFFFF_FFFC);
            chk({nm, "_arprot"}, {29'd0, log_arprot}, instr ? 32'd4 : 32'd0);
            chk({nm, "_ar_beats"}, ar_beats - ar0, 1);
        end
    endtask

    initial begin
        logic [32:0] m;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 1);
        chk("rst_valids", {26'd0, rsp_valid, arvalid, awvalid, wvalid, rready, bready}, 0);
        chk("rst_rsp", {rsp_rdata[30:0], rsp_err}, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_awaddr_wdata", awaddr | wdata, 0);
        chk("rst_wstrb", {28'd0, wstrb}, 0);
        #1 rstn = 1;

        m = model(0, 0, 32'h13, 3'b000, 32'h80123456, 0, 0); chk("pin_lb", m[31:0], 32'hFFFFFF80);
        m = model(0, 0, 32'h13, 3'b100, 32'h80123456, 0, 0); chk("pin_lbu", m[31:0], 32'h00000080);
        m = model(0, 0, 32'h12, 3'b001, 32'h80123456, 0, 0); chk("pin_lh", m[31:0], 32'hFFFF8012);
        m = model(0, 0, 32'h11, 3'b010, 32'h0, 0, 0);        chk("pin_misal_err", {31'd0, m[32]}, 1);
        chk("pin_sh_wdata", exp_wdata(3'b001, 32'h1234ABCD), 32'hABCDABCD);
        chk("pin_sh_wstrb", {28'd0, exp_strb(3'b001, 32'h22)}, 32'hC);

        do_req("lw",   0, 0, 32'h10, 3'b010, 0, 32'hDEADBEEF, 2'b00, 2'b00);
        do_req("lb",   0, 0, 32'h13, 3'b000, 0, 32'h80123456, 2'b00, 2'b00);
        do_req("lbu",  0, 0, 32'h13, 3'b100, 0, 32'h80123456, 2'b00, 2'b00);
        do_req("lh",   0, 0, 32'h12, 3'b001, 0, 32'h80123456, 2'b00, 2'b00);
        do_req("lhu",  0, 0, 32'h12, 3'b101, 0, 32'h80123456, 2'b00, 2'b00);
        do_req("lb1",  0, 0, 32'h11, 3'b000, 0, 32'h80123456, 2'b00, 2'b00);
        aw_delay = 3;
        do_req("sh",   1, 0, 32'h22, 3'b001, 32'h1234ABCD, 0, 2'b00, 2'b00);
        aw_delay = 0; w_delay = 2;
        do_req("sb",   1, 0, 32'h07, 3'b000, 32'hCAFE00AB, 0, 2'b00, 2'b00);
        w_delay = 0;
        do_req("sw",   1, 0, 32'h40, 3'b010, 32'h01234567, 0, 2'b00, 2'b00);
        do_req("lwmis", 0, 0, 32'h11, 3'b010, 0, 32'h11111111, 2'b00, 2'b00);
        do_req("f011", 0, 0, 32'h10, 3'b011, 0, 32'h11111111, 2'b00, 2'b00);
        do_req("lhmis", 0, 0, 32'h13, 3'b001, 0, 32'h11111111, 2'b00, 2'b00);
        do_req("sbad", 1, 0, 32'h10, 3'b100, 32'h1, 0, 2'b00, 2'b00);
        do_req("fetch", 0, 1, 32'h04, 3'b000, 0, 32'h00000013, 2'b10, 2'b00);
        do_req("swerr", 1, 0, 32'h08, 3'b010, 32'h89ABCDEF, 0, 2'b00, 2'b10);

        r_hold = 1;
        @(negedge clk);
        req_valid = 1; req_we = 0; req_instr = 0; req_addr = 32'h30; req_funct3 = 3'b010;
        @(negedge clk);
        req_valid = 0;
        for (int i = 0; i < 10 && !rready; i++) @(negedge clk);
        chk("abort_in_rd_data", {31'd0, rready}, 1);
        #2 rstn = 0;
        #1;
        chk("abort_arvalid", {31'd0, arvalid}, 0);
        chk("abort_rready", {31'd0, rready}, 0);
        chk("abort_req_ready", {31'd0, req_ready}, 1);
        @(negedge clk);
        #1 rstn = 1; r_hold = 0;
        repeat (5) @(negedge clk);
        chk("post_abort_req_ready", {31'd0, req_ready}, 1);
        do_req("lw_after", 0, 0, 32'h5C, 3'b010, 0, 32'h0BADF00D, 2'b00, 2'b00);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
